// File: rtl/tetris_key_pkg.sv
// Shared scancode constants, decoder state type and key lookup for the
// PS/2 move decoder.
package tetris_key_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_X_LEFT  = 8'h6B;
  localparam logic [7:0] SC_X_RIGHT = 8'h74;
  localparam logic [7:0] SC_X_DOWN  = 8'h72;
  localparam logic [7:0] SC_X_RO    = 8'h75;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_RO      = 8'h1D;

  localparam logic [1:0] LEFT_IDX  = 2'd0;
  localparam logic [1:0] RIGHT_IDX = 2'd1;
  localparam logic [1:0] DOWN_IDX  = 2'd2;
  localparam logic [1:0] RO_IDX    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_t;

  function automatic key_t key_lookup(
    input logic [7:0] code,
    input logic       ext
  );
    key_t k;
    k.hit = 1'b1;
    k.idx = LEFT_IDX;
    if (ext) begin
      case (code)
        SC_X_LEFT:  k.idx = LEFT_IDX;
        SC_X_RIGHT: k.idx = RIGHT_IDX;
        SC_X_DOWN:  k.idx = DOWN_IDX;
        SC_X_RO:    k.idx = RO_IDX;
        default:    k.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  k.idx = LEFT_IDX;
        SC_RIGHT: k.idx = RIGHT_IDX;
        SC_DOWN:  k.idx = DOWN_IDX;
        SC_RO:    k.idx = RO_IDX;
        default:  k.hit = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Command bundle from the PS/2 move decoder to the move-update logic.
// master drives pulses/held/scan status; slave consumes them.
interface ps2_move_decoder_if;
  logic       left;
  logic       right;
  logic       down;
  logic       ro;
  logic [3:0] held;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output left, right, down, ro,
    output held, scan_byte, scan_valid, frame_err
  );

  modport slave (
    input left, right, down, ro,
    input held, scan_byte, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: sync, clock filter, bit counter, parity/stop check.
// Ports: clk, rst_n, ps2_clk, ps2_data in; data, valid, err out.
// Optional stall timeout under `FRAME_TIMEOUT_EN.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          ck_s1, ck_s2;
  logic          dt_s1, dt_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic [3:0]    bitcnt;
  logic [9:0]    sh;
  logic          ok;
  logic          tout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      dt_s1 <= 1'b1;
      dt_s2 <= 1'b1;
    end else begin
      ck_s1 <= ps2_clk;
      ck_s2 <= ck_s1;
      dt_s1 <= ps2_data;
      dt_s2 <= dt_s1;
    end
  end

  // fcnt counts consecutive samples that disagree with filt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (ck_s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      filt <= ck_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign fall = filt & ~ck_s2 &
                (fcnt == FW'(FILTER_LEN - 1));

  // sh[0]=start, sh[8:1]=d0..d7, sh[9]=parity
  assign ok = ~sh[0] & (^sh[9:1]) & dt_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      sh     <= '0;
      data   <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (fall) begin
        if (bitcnt == 4'd10) begin
          bitcnt <= '0;
          if (ok) begin
            data  <= sh[8:1];
            valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end else begin
          sh     <= {dt_s2, sh[9:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (tout) begin
        bitcnt <= '0;
        err    <= 1'b1;
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;

  assign tout = (bitcnt != 4'd0) & ~fall &
                (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (fall || bitcnt == 4'd0 || tout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tout = 1'b0;
`endif

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 scancode to Tetris move pulses (left/right/down/ro) + held.
// Ports: clk, rst_n, ps2_clk, ps2_data; mv (master) carries all outputs.
// Optional frame stall timeout: define FRAME_TIMEOUT_EN.
module ps2_move_decoder
  import tetris_key_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_move_decoder_if.master   mv
);

  logic [7:0] data;
  logic       valid;
  logic       err;
  dec_state_t st;
  logic [3:0] held;
  logic [3:0] pls;
  key_t       k_n;
  key_t       k_x;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .valid    (valid),
    .err      (err)
  );

  assign k_n = key_lookup(data, 1'b0);
  assign k_x = key_lookup(data, 1'b1);

  // held suppresses typematic repeats until the break code arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      held <= '0;
      pls  <= '0;
    end else begin
      pls <= '0;
      if (err) begin
        st <= ST_IDLE;
      end else if (valid) begin
        unique case (st)
          ST_IDLE: begin
            unique case (1'b1)
              (data == SC_EXT): st <= ST_EXT;
              (data == SC_BRK): st <= ST_BRK;
              default: begin
                if (k_n.hit && !held[k_n.idx]) begin
                  held[k_n.idx] <= 1'b1;
                  pls[k_n.idx]  <= 1'b1;
                end
              end
            endcase
          end
          ST_EXT: begin
            if (data == SC_BRK) begin
              st <= ST_EXT_BRK;
            end else begin
              st <= ST_IDLE;
              if (k_x.hit && !held[k_x.idx]) begin
                held[k_x.idx] <= 1'b1;
                pls[k_x.idx]  <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            st <= ST_IDLE;
            if (k_n.hit) held[k_n.idx] <= 1'b0;
          end
          ST_EXT_BRK: begin
            st <= ST_IDLE;
            if (k_x.hit) held[k_x.idx] <= 1'b0;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  assign mv.left       = pls[LEFT_IDX];
  assign mv.right      = pls[RIGHT_IDX];
  assign mv.down       = pls[DOWN_IDX];
  assign mv.ro         = pls[RO_IDX];
  assign mv.held       = held;
  assign mv.scan_byte  = data;
  assign mv.scan_valid = valid;
  assign mv.frame_err  = err;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder: bit-banged PS/2 frames,
// pulse counting monitor, hand-computed expected counts and held state.
module tb_ps2_move_decoder;

  localparam int TO = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int total = 0;
  int bad = 0;
  int n_left = 0, n_right = 0, n_down = 0, n_ro = 0;
  int n_valid = 0, n_err = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_pv = '0;
  logic [3:0] pv;

  ps2_move_decoder_if mv ();

  ps2_move_decoder #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .mv       (mv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    pv = {mv.ro, mv.down, mv.right, mv.left};
    if (rst_n) begin
      if (pv != 4'b0) begin
        chk("onehot", $countones(pv), 1);
        chk("lat_after_valid", {31'b0, prev_valid}, 1);
        chk("width", {28'b0, prev_pv}, 0);
      end
      n_left  += int'(mv.left);
      n_right += int'(mv.right);
      n_down  += int'(mv.down);
      n_ro    += int'(mv.ro);
      n_valid += int'(mv.scan_valid);
      n_err   += int'(mv.frame_err);
    end
    prev_valid = mv.scan_valid;
    prev_pv = pv;
  end

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic flip = 1'b0);
    send_bits(frame(b, flip), 11);
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_pulses"},
        {28'b0, mv.ro, mv.down, mv.right, mv.left}, 0);
    chk({tag, "_held"}, {28'b0, mv.held}, 0);
    chk({tag, "_byte"}, {24'b0, mv.scan_byte}, 0);
    chk({tag, "_flags"},
        {30'b0, mv.scan_valid, mv.frame_err}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_outs_zero("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_outs_zero("idle");

    send(8'hE0); send(8'h6B);
    chk("t1_left", n_left, 1);
    chk("t1_held", {28'b0, mv.held}, 4'b0001);
    chk("t1_byte", {24'b0, mv.scan_byte}, 8'h6B);

    send(8'hE0); send(8'h6B);
    chk("t2_repeat_left", n_left, 1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("t2_left", n_left, 1);
    chk("t2_held", {28'b0, mv.held}, 4'b0000);

    send(8'h1D);
    chk("t3_ro", n_ro, 1);
    chk("t3_held_set", {28'b0, mv.held}, 4'b1000);
    send(8'hF0); send(8'h1D);
    chk("t3_held_clr", {28'b0, mv.held}, 4'b0000);
    chk("t3_ro_once", n_ro, 1);
    chk("t3_others", n_left + n_right + n_down, 1);

    send(8'hE0);
    send(8'h6B, 1'b1);
    chk("t4_err", n_err, 1);
    chk("t4_byte_kept", {24'b0, mv.scan_byte}, 8'hE0);
    send(8'h6B);
    chk("t4_no_left", n_left, 1);
    chk("t4_byte", {24'b0, mv.scan_byte}, 8'h6B);
    chk("t4_valid_cnt", n_valid, 12);
    chk("t4_held", {28'b0, mv.held}, 4'b0000);

    send(8'h1C);
    chk("t5_a_left", n_left, 2);
    chk("t5_a_held", {28'b0, mv.held}, 4'b0001);
    send(8'hE0); send(8'h6B);
    chk("t5_shared_held", n_left, 2);

    send_bits(frame(8'h72, 1'b0), 5);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs_zero("t6_rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(8'hE0); send(8'h72);
    chk("t6_down", n_down, 1);
    chk("t6_held", {28'b0, mv.held}, 4'b0100);
    chk("t6_no_err", n_err, 1);
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("t6_held_clr", {28'b0, mv.held}, 4'b0000);
    send(8'h1C);
    chk("t6_left_after_rst", n_left, 3);

`ifdef FRAME_TIMEOUT_EN
    send_bits(frame(8'h74, 1'b0), 4);
    repeat (TO + 10) @(negedge clk);
    chk("to_err", n_err, 2);
    send(8'hE0); send(8'h74);
    chk("to_right", n_right, 1);
    chk("to_err_once", n_err, 2);
`else
    chk("right_none", n_right, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
